// File: rtl/coverfloat_sample_sched.sv
// rtl/coverfloat_sample_sched.sv - round-robin scheduler feeding one coverage sampler from NUM_REQ FP transaction sources
module coverfloat_sample_sched #(
    parameter int NUM_REQ = 4,
    parameter int PAY_W   = 512,
    parameter int CNT_W   = 32,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_enable,
    input  logic [31:0]              cfg_op_en,
    input  logic                     cfg_clear,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*32-1:0]    req_op,
    input  logic [NUM_REQ*8-1:0]     req_flags,
    input  logic [NUM_REQ*PAY_W-1:0] req_payload,
    output logic                     smp_valid,
    input  logic                     smp_ready,
    output logic [31:0]              smp_op,
    output logic [7:0]               smp_flags,
    output logic [PAY_W-1:0]         smp_payload,
    output logic [SRC_W-1:0]         smp_src,
    output logic [CNT_W-1:0]         cnt_issued,
    output logic [CNT_W-1:0]         cnt_dropped,
    output logic [5*CNT_W-1:0]       cnt_flag
);

    logic                   r_valid;
    logic [31:0]            r_op;
    logic [7:0]             r_flags;
    logic [PAY_W-1:0]       r_payload;
    logic [SRC_W-1:0]       r_src;
    logic [SRC_W-1:0]       r_ptr;
    logic [CNT_W-1:0]       r_cnt_issued;
    logic [CNT_W-1:0]       r_cnt_dropped;
    logic [4:0][CNT_W-1:0]  r_cnt_flag;

    logic                   w_can_load;
    logic                   w_gnt_found;
    logic [SRC_W-1:0]       w_gnt_idx;
    logic [31:0]            w_op;
    logic [7:0]             w_flags;
    logic [PAY_W-1:0]       w_payload;
    int                     w_best;
    int                     w_dist;
    logic                   w_grant;
    logic                   w_legal;
    logic                   w_load;
    logic                   w_drop;
    logic                   w_issue;
    logic [NUM_REQ-1:0]     w_ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_can_load = !r_valid || smp_ready;

    // Distance 0 is the lane right after ptr; the closest valid lane wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_op        = '0;
        w_flags     = '0;
        w_payload   = '0;
        w_best      = NUM_REQ;
        w_dist      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(r_ptr)) % NUM_REQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_gnt_found = 1'b1;
                w_gnt_idx   = SRC_W'(i);
                w_op        = req_op[32*i +: 32];
                w_flags     = req_flags[8*i +: 8];
                w_payload   = req_payload[PAY_W*i +: PAY_W];
            end
        end
    end

    assign w_grant = rst_n && cfg_enable && w_can_load && w_gnt_found;
    assign w_legal = (w_op[31:9] == 23'd0) && cfg_op_en[w_op[8:4]];
    assign w_load  = w_grant && w_legal;
    assign w_drop  = w_grant && !w_legal;
    assign w_issue = r_valid && smp_ready;

    always_comb begin
        w_ready = '0;
        if (w_grant) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign req_ready   = w_ready;
    assign smp_valid   = r_valid;
    assign smp_op      = r_op;
    assign smp_flags   = r_flags;
    assign smp_payload = r_payload;
    assign smp_src     = r_src;
    assign cnt_issued  = r_cnt_issued;
    assign cnt_dropped = r_cnt_dropped;
    assign cnt_flag    = r_cnt_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_op          <= '0;
            r_flags       <= '0;
            r_payload     <= '0;
            r_src         <= '0;
            r_ptr         <= SRC_W'(NUM_REQ - 1);
            r_cnt_issued  <= '0;
            r_cnt_dropped <= '0;
            r_cnt_flag    <= '0;
        end else begin
            if (w_grant) begin
                r_ptr <= w_gnt_idx;
            end
            if (w_load) begin
                r_valid   <= 1'b1;
                r_op      <= w_op;
                r_flags   <= w_flags;
                r_payload <= w_payload;
                r_src     <= w_gnt_idx;
            end else if (w_issue) begin
                r_valid <= 1'b0;
            end
            // Clear wins over any increment landing in the same cycle.
            if (cfg_clear) begin
                r_cnt_issued  <= '0;
                r_cnt_dropped <= '0;
                r_cnt_flag    <= '0;
            end else begin
                if (w_drop) begin
                    r_cnt_dropped <= sat_inc(r_cnt_dropped);
                end
                if (w_issue) begin
                    r_cnt_issued <= sat_inc(r_cnt_issued);
                    for (int k = 0; k < 5; k++) begin
                        if (r_flags[k]) begin
                            r_cnt_flag[k] <= sat_inc(r_cnt_flag[k]);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_coverfloat_sample_sched.sv
// tb/tb_coverfloat_sample_sched.sv - directed self-checking bench for coverfloat_sample_sched
module tb_coverfloat_sample_sched;

    localparam int NUM_REQ = 4;
    localparam int PAY_W   = 32;
    localparam int CNT_W   = 4;
    localparam int SRC_W   = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     cfg_enable;
    logic [31:0]              cfg_op_en;
    logic                     cfg_clear;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*32-1:0]    req_op;
    logic [NUM_REQ*8-1:0]     req_flags;
    logic [NUM_REQ*PAY_W-1:0] req_payload;
    logic                     smp_valid;
    logic                     smp_ready;
    logic [31:0]              smp_op;
    logic [7:0]               smp_flags;
    logic [PAY_W-1:0]         smp_payload;
    logic [SRC_W-1:0]         smp_src;
    logic [CNT_W-1:0]         cnt_issued;
    logic [CNT_W-1:0]         cnt_dropped;
    logic [5*CNT_W-1:0]       cnt_flag;

    int total = 0;
    int bad   = 0;

    coverfloat_sample_sched #(
        .NUM_REQ(NUM_REQ), .PAY_W(PAY_W), .CNT_W(CNT_W), .SRC_W(SRC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_op_en(cfg_op_en),
        .cfg_clear(cfg_clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_flags(req_flags), .req_payload(req_payload),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_op(smp_op),
        .smp_flags(smp_flags), .smp_payload(smp_payload), .smp_src(smp_src),
        .cnt_issued(cnt_issued), .cnt_dropped(cnt_dropped), .cnt_flag(cnt_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_counters();
        @(negedge clk);
        cfg_clear = 1'b1;
        @(negedge clk);
        cfg_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_enable = 1'b1; cfg_op_en = 32'hFFFF_FFFF; cfg_clear = 1'b0;
        req_valid = 4'b1111; smp_ready = 1'b1; req_flags = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_op[32*i +: 32]         = 32'h10 * (i + 1);
            req_payload[PAY_W*i +: PAY_W] = 32'hA0 + i;
        end
        repeat (3) @(negedge clk);
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        total++; if (smp_valid !== 1'b0 || smp_op !== 32'h0 || smp_src !== 2'd0 || smp_payload !== 32'h0) begin
            bad++; $display("FAIL reset_slot got v=%b op=%h src=%0d exp all zero", smp_valid, smp_op, smp_src); end
        total++; if (cnt_issued !== 4'd0 || cnt_dropped !== 4'd0 || cnt_flag !== 20'd0) begin
            bad++; $display("FAIL reset_cnt got iss=%0d drp=%0d flg=%h exp 0", cnt_issued, cnt_dropped, cnt_flag); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            total++; if (req_ready !== 4'(1 << (c % 4))) begin
                bad++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, 4'(1 << (c % 4))); end
            @(posedge clk); #1;
            total++; if (smp_valid !== 1'b1 || smp_src !== 2'(c % 4) || smp_op !== 32'h10 * ((c % 4) + 1)) begin
                bad++; $display("FAIL rr_slot c=%0d got v=%b src=%0d op=%h exp src=%0d", c, smp_valid, smp_src, smp_op, c % 4); end
            @(negedge clk);
        end
        req_valid = '0;
        @(posedge clk); #1;
        total++; if (cnt_issued !== 4'd8 || smp_valid !== 1'b0) begin
            bad++; $display("FAIL rr_issued got=%0d v=%b exp=8 v=0", cnt_issued, smp_valid); end
    endtask

    task automatic test_backpressure();
        clear_counters();
        smp_ready = 1'b0;
        req_valid = 4'b0001;
        req_op[31:0] = 32'h20; req_payload[31:0] = 32'hCAFE;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_first_ready got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_op[31:0] = 32'h30; req_payload[31:0] = 32'hBEEF;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (req_ready !== 4'b0000 || smp_valid !== 1'b1 || smp_op !== 32'h20 || smp_payload !== 32'hCAFE) begin
                bad++; $display("FAIL bp_hold c=%0d got rdy=%b v=%b op=%h pay=%h exp 0000/1/20/cafe", c, req_ready, smp_valid, smp_op, smp_payload); end
            @(negedge clk);
        end
        smp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_drain_grant got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        total++; if (smp_op !== 32'h30 || smp_payload !== 32'hBEEF || cnt_issued !== 4'd1) begin
            bad++; $display("FAIL bp_reload got op=%h pay=%h iss=%0d exp 30/beef/1", smp_op, smp_payload, cnt_issued); end
        @(negedge clk);
        req_valid = '0;
        @(posedge clk); #1;
        total++; if (smp_valid !== 1'b0 || cnt_issued !== 4'd2) begin
            bad++; $display("FAIL bp_end got v=%b iss=%0d exp 0/2", smp_valid, cnt_issued); end
    endtask

    task automatic test_filter();
        clear_counters();
        cfg_op_en = 32'hFFFF_FFDF;
        req_op[31:0] = 32'h53; req_op[63:32] = 32'h10;
        req_valid = 4'b0011;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL flt_ready1 got=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        total++; if (smp_valid !== 1'b1 || smp_src !== 2'd1 || smp_op !== 32'h10) begin
            bad++; $display("FAIL flt_slot1 got v=%b src=%0d op=%h exp 1/1/10", smp_valid, smp_src, smp_op); end
        @(negedge clk); #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL flt_ready0 got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        total++; if (cnt_dropped !== 4'd1 || cnt_issued !== 4'd1 || smp_valid !== 1'b0) begin
            bad++; $display("FAIL flt_drop got drp=%0d iss=%0d v=%b exp 1/1/0", cnt_dropped, cnt_issued, smp_valid); end
        cfg_op_en = 32'hFFFF_FFFF;
        req_op[31:0] = 32'h200;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        #1;
        total++; if (cnt_dropped !== 4'd2 || smp_valid !== 1'b0) begin
            bad++; $display("FAIL flt_high_op got drp=%0d v=%b exp 2/0", cnt_dropped, smp_valid); end
    endtask

    task automatic test_flags();
        logic [7:0] fl [3];
        fl[0] = 8'h01; fl[1] = 8'h11; fl[2] = 8'hE4;
        clear_counters();
        req_op[31:0] = 32'h10;
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            req_flags[7:0] = fl[c];
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk); #1;
        total++; if (cnt_flag[0 +: 4] !== 4'd2 || cnt_flag[4 +: 4] !== 4'd0 || cnt_flag[8 +: 4] !== 4'd1 ||
                     cnt_flag[12 +: 4] !== 4'd0 || cnt_flag[16 +: 4] !== 4'd1) begin
            bad++; $display("FAIL flags_cnt got=%h exp=10102", cnt_flag); end
        total++; if (cnt_issued !== 4'd3) begin bad++; $display("FAIL flags_issued got=%0d exp=3", cnt_issued); end
        req_flags = '0;
    endtask

    task automatic test_saturation();
        clear_counters();
        req_valid = 4'b1111;
        repeat (20) @(negedge clk);
        req_valid = '0;
        @(negedge clk); #1;
        total++; if (cnt_issued !== 4'd15) begin bad++; $display("FAIL sat_issued got=%0d exp=15", cnt_issued); end
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        cfg_clear = 1'b1;
        @(negedge clk);
        cfg_clear = 1'b0;
        #1;
        total++; if (cnt_issued !== 4'd0 || smp_valid !== 1'b0) begin
            bad++; $display("FAIL clear_prio got iss=%0d v=%b exp 0/0", cnt_issued, smp_valid); end
    endtask

    task automatic test_enable_off();
        smp_ready = 1'b0;
        req_valid = 4'b0001;
        @(negedge clk);
        cfg_enable = 1'b0;
        smp_ready  = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0000 || smp_valid !== 1'b1) begin
            bad++; $display("FAIL en_off got rdy=%b v=%b exp 0000/1", req_ready, smp_valid); end
        @(negedge clk); #1;
        total++; if (smp_valid !== 1'b0 || cnt_issued !== 4'd1) begin
            bad++; $display("FAIL en_drain got v=%b iss=%0d exp 0/1", smp_valid, cnt_issued); end
        req_valid = '0;
        cfg_enable = 1'b1;
    endtask

    task automatic test_async_reset();
        req_valid = 4'b0100;
        smp_ready = 1'b0;
        @(negedge clk);
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (smp_valid !== 1'b0 || smp_op !== 32'h0 || cnt_issued !== 4'd0 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL arst got v=%b op=%h iss=%0d rdy=%b exp 0", smp_valid, smp_op, cnt_issued, req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        smp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL arst_first got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_filter();
        test_flags();
        test_saturation();
        test_enable_off();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coverfloat_sample_sched.md
Name: coverfloat_sample_sched

Overview:
- Round-robin scheduler that shares the single coverage sampler between NUM_REQ transaction sources, such as per-lane FPU monitors or vector replayers.
- Each request is one completed FP transaction: op code in the major/variant encoding, result flags, and an opaque payload carrying operands, rounding mode, formats and result.
- Filters transactions by a per-major-op enable mask and registers accepted ones into a one-deep output slot with valid/ready.
- Keeps saturating issue, drop and per-flag event counters for run summaries.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
PAY_W, 512, opaque payload width per transaction
CNT_W, 32, width of every statistics counter
SRC_W, $clog2(NUM_REQ), source index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_enable  input  1  when 0, no new grants are made; the output slot still drains
cfg_op_en  input  32  enable mask for major ops, indexed by op[8:4]
cfg_clear  input  1  synchronous clear pulse for all counters
req_valid  input  NUM_REQ  per-requester valid
req_ready  output  NUM_REQ  per-requester ready, one-hot or zero
req_op  input  NUM_REQ*32  packed op codes, requester i at [32*i +: 32]
req_flags  input  NUM_REQ*8  packed exception flags
req_payload  input  NUM_REQ*PAY_W  packed payloads
smp_valid  output  1  output slot holds a transaction
smp_ready  input  1  sampler accepts
smp_op  output  32  registered op
smp_flags  output  8  registered flags
smp_payload  output  PAY_W  registered payload
smp_src  output  SRC_W  index of the granted requester
cnt_issued  output  CNT_W  transactions handed to the sampler
cnt_dropped  output  CNT_W  transactions accepted but filtered out
cnt_flag  output  5*CNT_W  per-flag counts; slice k counts flag bit k (0 inexact, 1 underflow, 2 overflow, 3 infinite, 4 invalid)

Behaviour:
- Reset, asynchronous on rst_n low:
  - smp_valid=0; smp_op, smp_flags, smp_payload and smp_src are 0.
  - All counters are 0.
  - Round-robin pointer ptr is NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0 while rst_n is low.
- Slot state:
  - EMPTY when smp_valid=0, FULL when smp_valid=1.
  - can_load = !smp_valid | smp_ready.
- Grant (combinational):
  - Active only if cfg_enable & can_load.
  - Selects the first i with req_valid[i]=1, searching ptr+1, ptr+2, … modulo NUM_REQ.
  - req_ready[i]=1 for that i only. The handshake completes in the same cycle.
  - req_ready must not depend on req_valid of the granted lane beyond selection; there is no combinational path from smp_ready to req_ready other than through can_load.
- Filter: a granted transaction is legal iff op[31:9]==0 and cfg_op_en[op[8:4]]==1. Variant bits op[3:0] are ignored, so variant 5_3 is governed by mask bit 5.
- On grant (rising edge):
  - ptr becomes i, whether or not the transaction is filtered.
  - Legal: slot loads op, flags, payload and src=i; smp_valid=1 the next cycle. Latency is 1 cycle from req handshake to smp_valid.
  - Filtered: cnt_dropped increments; slot is not loaded. smp_valid falls if the slot was draining this cycle, otherwise it is unchanged.
- Drain: smp_valid & smp_ready with no legal load this cycle → smp_valid=0 next cycle.
  - With continuous smp_ready and requests present, throughput is 1 transaction per cycle.
- Slot stability: while smp_valid=1 and smp_ready=0, all smp_* outputs are held stable and every req_ready is 0.
- Issue counting: on each smp_valid & smp_ready:
  - cnt_issued increments.
  - For each k in 0..4 with smp_flags[k]=1, cnt_flag slice k increments.
  - Bits 7:5 of smp_flags are ignored.
- Counters saturate at 2^CNT_W-1.
- cfg_clear zeroes all counters and has priority over increments in the same cycle. It does not affect the slot or ptr.
- cfg_enable falling with the slot FULL: the held transaction remains and drains normally; no new grants are made.
- Reset mid-operation: the held transaction is discarded and no counter reflects it.

Test Plan:
- Reset, then req_valid=4'b1111 with smp_ready=1 and all mask bits set → grants 0,1,2,3,0… on consecutive cycles; smp_src follows 1 cycle later; cnt_issued=8 after 8 issue cycles.
- Backpressure: req0 only, smp_ready=0 for 5 cycles → smp_valid=1 with op/payload stable; req_ready=0 for 4 cycles after the load; after smp_ready=1, next grant occurs in the same cycle as the drain.
- Filter: cfg_op_en=0xFFFF_FFFF except bit 5 clear; req0 op=32'h53, req1 op=32'h10 → req0 accepted with cnt_dropped=1 and never on smp; req1 issued; op=32'h200 is dropped for any mask.
- Flags: issue three transactions with flags 8'h01, 8'h11, 8'hE4 → cnt_flag = {invalid 1, infinite 0, overflow 1, underflow 0, inexact 2}.
- Saturation and clear with CNT_W=4: 20 issues → cnt_issued=15; cfg_clear coincident with an issue → cnt_issued=0.
- Asynchronous reset asserted while FULL, mid-cycle → smp_valid=0 immediately; after release, requester 0 is granted first.
